// File: rtl/riscv_defs.sv
// rtl/riscv_defs.sv - shared definitions for the core-to-memory arbiter
package riscv_defs;

  localparam int TAG_W = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BUSY_I,
    ST_BUSY_D,
    ST_RESP,
    ST_RESP_ERR
  } arb_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/riscv_rr_arbiter2.sv
// rtl/riscv_rr_arbiter2.sv - two-requester round-robin grant with last-grant register
module riscv_rr_arbiter2 #(
  parameter bit FIRST_B = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic req_a_i,
  input  logic req_b_i,
  output logic grant_a_o,
  output logic grant_b_o
);

  logic last_b_q;
  logic pick_b;

  // On a tie, b wins unless it was the most recent winner.
  assign pick_b    = req_b_i & (~req_a_i | ~last_b_q);
  assign grant_b_o = en_i & pick_b;
  assign grant_a_o = en_i & req_a_i & ~pick_b;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_b_q <= ~FIRST_B;
    end else if (grant_a_o | grant_b_o) begin
      last_b_q <= grant_b_o;
    end
  end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// rtl/riscv_mem_arbiter.sv - shares one memory controller between fetch and data ports
module riscv_mem_arbiter
  import riscv_defs::*;
#(
  parameter logic [31:0] MEM_ADDR_MAX   = 32'h0000_FFFF,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter bit          DATA_FIRST     = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             mem_i_rd_i,
  input  logic [31:0]      mem_i_pc_i,
  input  logic             mem_i_flush_i,
  output logic             mem_i_accept_o,
  output logic             mem_i_valid_o,
  output logic             mem_i_error_o,
  output logic [31:0]      mem_i_inst_o,
  input  logic [31:0]      mem_d_addr_i,
  input  logic [31:0]      mem_d_data_wr_i,
  input  logic             mem_d_rd_i,
  input  logic [3:0]       mem_d_wr_i,
  input  logic [TAG_W-1:0] mem_d_req_tag_i,
  output logic             mem_d_accept_o,
  output logic             mem_d_ack_o,
  output logic             mem_d_error_o,
  output logic [31:0]      mem_d_data_rd_o,
  output logic [TAG_W-1:0] mem_d_resp_tag_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  output logic [3:0]       mem_wstrb_o,
  output logic             mem_we_o,
  output logic             mem_re_o,
  input  logic             mem_ready_i,
  input  logic [31:0]      mem_rdata_i
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t       state_q;
  logic [CNT_W-1:0] tmo_cnt_q;
  logic             owner_d_q;
  logic             flushed_q;
  logic [TAG_W-1:0] tag_q;

  logic             i_valid_q, i_err_q;
  logic [31:0]      i_inst_q;
  logic             d_ack_q, d_err_q;
  logic [31:0]      d_rdata_q;
  logic [TAG_W-1:0] d_tag_q;

  logic        req_d, req_i, grant_d, grant_i, arb_en;
  logic [31:0] acc_addr;
  logic        acc_range_err;
  logic        busy_done, busy_err;

  assign req_d  = mem_d_rd_i | (|mem_d_wr_i);
  assign req_i  = mem_i_rd_i;
  assign arb_en = (state_q == ST_IDLE) & ~rst_i;

  riscv_rr_arbiter2 #(
    .FIRST_B (DATA_FIRST)
  ) u_rr (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (arb_en),
    .req_a_i   (req_i),
    .req_b_i   (req_d),
    .grant_a_o (grant_i),
    .grant_b_o (grant_d)
  );

  assign acc_addr      = grant_d ? mem_d_addr_i : mem_i_pc_i;
  assign acc_range_err = acc_addr > MEM_ADDR_MAX;
  assign busy_done     = mem_ready_i | (tmo_cnt_q == TMO_LAST);
  assign busy_err      = ~mem_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      tmo_cnt_q   <= '0;
      owner_d_q   <= 1'b0;
      flushed_q   <= 1'b0;
      tag_q       <= '0;
      i_valid_q   <= 1'b0;
      i_err_q     <= 1'b0;
      i_inst_q    <= '0;
      d_ack_q     <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
      d_tag_q     <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_wstrb_o <= '0;
      mem_we_o    <= 1'b0;
      mem_re_o    <= 1'b0;
    end else begin
      // Response registers are pulses: cleared unless loaded this cycle.
      i_valid_q <= 1'b0;
      i_err_q   <= 1'b0;
      i_inst_q  <= '0;
      d_ack_q   <= 1'b0;
      d_err_q   <= 1'b0;
      d_rdata_q <= '0;
      d_tag_q   <= '0;

      case (state_q)
        ST_IDLE: begin
          if (grant_d | grant_i) begin
            owner_d_q <= grant_d;
            tag_q     <= grant_d ? mem_d_req_tag_i : '0;
            flushed_q <= 1'b0;
            tmo_cnt_q <= '0;
            if (acc_range_err) begin
              state_q <= ST_RESP_ERR;
              if (grant_d) begin
                d_ack_q <= 1'b1;
                d_err_q <= 1'b1;
                d_tag_q <= mem_d_req_tag_i;
              end else begin
                i_valid_q <= 1'b1;
                i_err_q   <= 1'b1;
              end
            end else begin
              mem_addr_o <= word_align(acc_addr);
              if (grant_d && (|mem_d_wr_i)) begin
                mem_we_o    <= 1'b1;
                mem_wstrb_o <= mem_d_wr_i;
                mem_wdata_o <= mem_d_data_wr_i;
              end else begin
                mem_re_o <= 1'b1;
              end
              state_q <= grant_d ? ST_BUSY_D : ST_BUSY_I;
            end
          end
        end

        ST_BUSY_I, ST_BUSY_D: begin
          if (state_q == ST_BUSY_I && mem_i_flush_i) begin
            flushed_q <= 1'b1;
          end
          if (busy_done) begin
            mem_re_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_wstrb_o <= '0;
            mem_wdata_o <= '0;
            mem_addr_o  <= '0;
            state_q     <= busy_err ? ST_RESP_ERR : ST_RESP;
            if (owner_d_q) begin
              d_ack_q   <= 1'b1;
              d_err_q   <= busy_err;
              d_rdata_q <= busy_err ? 32'h0 : mem_rdata_i;
              d_tag_q   <= tag_q;
            end else begin
              i_valid_q <= ~(flushed_q | mem_i_flush_i);
              i_err_q   <= busy_err & ~(flushed_q | mem_i_flush_i);
              i_inst_q  <= busy_err ? 32'h0 : mem_rdata_i;
            end
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end

        ST_RESP, ST_RESP_ERR: state_q <= ST_IDLE;

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_i_accept_o   = grant_i;
  assign mem_d_accept_o   = grant_d;
  // A flush raised during the response cycle still drops the fetch response.
  assign mem_i_valid_o    = i_valid_q & ~mem_i_flush_i;
  assign mem_i_error_o    = i_err_q & ~mem_i_flush_i;
  assign mem_i_inst_o     = i_inst_q;
  assign mem_d_ack_o      = d_ack_q;
  assign mem_d_error_o    = d_err_q;
  assign mem_d_data_rd_o  = d_rdata_q;
  assign mem_d_resp_tag_o = d_tag_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb/tb_riscv_mem_arbiter.sv - scoreboard bench for riscv_mem_arbiter
`timescale 1ns/1ps
module tb_riscv_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        mem_i_rd_i, mem_i_flush_i;
  logic [31:0] mem_i_pc_i;
  logic        mem_i_accept_o, mem_i_valid_o, mem_i_error_o;
  logic [31:0] mem_i_inst_o;
  logic [31:0] mem_d_addr_i, mem_d_data_wr_i;
  logic        mem_d_rd_i;
  logic [3:0]  mem_d_wr_i;
  logic [10:0] mem_d_req_tag_i;
  logic        mem_d_accept_o, mem_d_ack_o, mem_d_error_o;
  logic [31:0] mem_d_data_rd_o;
  logic [10:0] mem_d_resp_tag_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_we_o, mem_re_o, mem_ready_i;
  logic [31:0] mem_rdata_i;

  typedef struct {
    logic        is_d;
    logic        err;
    logic [31:0] data;
    logic [10:0] tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;
  int   seen_i = 0;
  logic stall = 1'b0;

  always #5 clk_i = ~clk_i;

  riscv_mem_arbiter #(
    .MEM_ADDR_MAX   (32'h0000_FFFF),
    .TIMEOUT_CYCLES (8),
    .DATA_FIRST     (1'b1)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .mem_i_rd_i       (mem_i_rd_i),
    .mem_i_pc_i       (mem_i_pc_i),
    .mem_i_flush_i    (mem_i_flush_i),
    .mem_i_accept_o   (mem_i_accept_o),
    .mem_i_valid_o    (mem_i_valid_o),
    .mem_i_error_o    (mem_i_error_o),
    .mem_i_inst_o     (mem_i_inst_o),
    .mem_d_addr_i     (mem_d_addr_i),
    .mem_d_data_wr_i  (mem_d_data_wr_i),
    .mem_d_rd_i       (mem_d_rd_i),
    .mem_d_wr_i       (mem_d_wr_i),
    .mem_d_req_tag_i  (mem_d_req_tag_i),
    .mem_d_accept_o   (mem_d_accept_o),
    .mem_d_ack_o      (mem_d_ack_o),
    .mem_d_error_o    (mem_d_error_o),
    .mem_d_data_rd_o  (mem_d_data_rd_o),
    .mem_d_resp_tag_o (mem_d_resp_tag_o),
    .mem_addr_o       (mem_addr_o),
    .mem_wdata_o      (mem_wdata_o),
    .mem_wstrb_o      (mem_wstrb_o),
    .mem_we_o         (mem_we_o),
    .mem_re_o         (mem_re_o),
    .mem_ready_i      (mem_ready_i),
    .mem_rdata_i      (mem_rdata_i)
  );

  function automatic logic [31:0] model_rdata(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0000_0013 : (a ^ 32'h5A5A_0000);
  endfunction

  // Downstream model: completes in the first request cycle unless stalled.
  assign mem_ready_i = (mem_re_o | mem_we_o) & ~stall;
  assign mem_rdata_i = (mem_re_o & ~stall) ? model_rdata(mem_addr_o) : 32'h0;

  always begin
    @(negedge clk_i);
    #2;
    if (mem_i_valid_o) begin
      seen_i++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL fetch_resp unexpected: inst=%h err=%b, required no response", mem_i_inst_o, mem_i_error_o);
      end else begin
        e = exp_q.pop_front();
        if (e.is_d !== 1'b0 || mem_i_error_o !== e.err || mem_i_inst_o !== e.data) begin
          fails++;
          $display("FAIL fetch_resp: port=fetch err=%b inst=%h, required port=%s err=%b inst=%h",
                   mem_i_error_o, mem_i_inst_o, e.is_d ? "data" : "fetch", e.err, e.data);
        end
      end
    end
    if (mem_d_ack_o) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL data_resp unexpected: data=%h err=%b tag=%h, required no response",
                 mem_d_data_rd_o, mem_d_error_o, mem_d_resp_tag_o);
      end else begin
        e = exp_q.pop_front();
        if (e.is_d !== 1'b1 || mem_d_error_o !== e.err || mem_d_data_rd_o !== e.data ||
            mem_d_resp_tag_o !== e.tag) begin
          fails++;
          $display("FAIL data_resp: port=data err=%b data=%h tag=%h, required port=%s err=%b data=%h tag=%h",
                   mem_d_error_o, mem_d_data_rd_o, mem_d_resp_tag_o, e.is_d ? "data" : "fetch",
                   e.err, e.data, e.tag);
        end
      end
    end
  end

  function automatic void push_exp(input logic is_d, input logic err, input logic [31:0] data,
                                   input logic [10:0] tag);
    exp_t x;
    x.is_d = is_d; x.err = err; x.data = data; x.tag = tag;
    exp_q.push_back(x);
  endfunction

  task automatic set_idle();
    mem_i_rd_i = 0; mem_i_pc_i = 0; mem_i_flush_i = 0;
    mem_d_addr_i = 0; mem_d_data_wr_i = 0; mem_d_rd_i = 0; mem_d_wr_i = 0; mem_d_req_tag_i = 0;
  endtask

  // Call right after a negedge; returns at negedge+1 of the accept cycle.
  task automatic wait_accept(output bit ok);
    ok = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (mem_i_accept_o | mem_d_accept_o) begin
        ok = 1;
        break;
      end
      @(negedge clk_i);
    end
  endtask

  task automatic wait_drain(output bit ok);
    ok = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      if (exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    set_idle();
    rst_i = 1;
    repeat (3) @(negedge clk_i);
    #1;
    tests++;
    if ({mem_i_accept_o, mem_i_valid_o, mem_i_error_o, mem_i_inst_o, mem_d_accept_o, mem_d_ack_o,
         mem_d_error_o, mem_d_data_rd_o, mem_d_resp_tag_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
         mem_we_o, mem_re_o} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: re=%b we=%b ack=%b valid=%b addr=%h, required all 0",
               mem_re_o, mem_we_o, mem_d_ack_o, mem_i_valid_o, mem_addr_o);
    end
    rst_i = 0;
  endtask

  task automatic test_tie();
    bit ok, exp_d;
    @(negedge clk_i);
    mem_i_rd_i = 1; mem_i_pc_i = 32'h0;
    mem_d_rd_i = 1; mem_d_addr_i = 32'h200; mem_d_req_tag_i = 11'h5;
    for (int k = 0; k < 4; k++) begin
      wait_accept(ok);
      exp_d = (k % 2 == 0);
      tests++;
      if (!ok || mem_d_accept_o !== exp_d || mem_i_accept_o !== !exp_d) begin
        fails++;
        $display("FAIL tie_grant_%0d: d_accept=%b i_accept=%b, required d_accept=%b i_accept=%b",
                 k, mem_d_accept_o, mem_i_accept_o, exp_d, !exp_d);
        break;
      end
      if (exp_d) push_exp(1, 0, model_rdata(32'h200), mem_d_req_tag_i);
      else       push_exp(0, 0, model_rdata(32'h0), 11'h0);
      @(negedge clk_i);
      if (exp_d) mem_d_req_tag_i = mem_d_req_tag_i + 1'b1;
    end
    set_idle();
    wait_drain(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL tie_drain: pending=%0d, required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    stall = 0;
    @(negedge clk_i);
    mem_i_rd_i = 1; mem_i_pc_i = 32'h100;
    #1;
    tests++;
    if (mem_i_accept_o !== 1'b1) begin
      fails++; $display("FAIL b2b_accept0: accept=%b, required 1", mem_i_accept_o);
    end
    push_exp(0, 0, 32'h0000_0013, 11'h0);
    @(negedge clk_i);
    mem_i_pc_i = 32'h104;
    #1;
    tests++;
    if (mem_i_accept_o !== 1'b0 || mem_re_o !== 1'b1 || mem_addr_o !== 32'h100) begin
      fails++;
      $display("FAIL b2b_busy: accept=%b re=%b addr=%h, required accept=0 re=1 addr=00000100",
               mem_i_accept_o, mem_re_o, mem_addr_o);
    end
    @(negedge clk_i);
    #1;
    tests++;
    if (mem_i_accept_o !== 1'b0 || mem_i_valid_o !== 1'b1 || mem_i_inst_o !== 32'h13) begin
      fails++;
      $display("FAIL b2b_resp_t2: accept=%b valid=%b inst=%h, required accept=0 valid=1 inst=00000013",
               mem_i_accept_o, mem_i_valid_o, mem_i_inst_o);
    end
    @(negedge clk_i);
    #1;
    tests++;
    if (mem_i_accept_o !== 1'b1) begin
      fails++; $display("FAIL b2b_accept_t3: accept=%b, required 1", mem_i_accept_o);
    end
    push_exp(0, 0, model_rdata(32'h104), 11'h0);
    @(negedge clk_i);
    set_idle();
    mem_d_rd_i = 1; mem_d_addr_i = 32'h207; mem_d_req_tag_i = 11'h9;
    wait_accept(ok);
    push_exp(1, 0, model_rdata(32'h204), 11'h9);
    @(negedge clk_i);
    set_idle();
    #1;
    tests++;
    if (mem_addr_o !== 32'h204 || mem_re_o !== 1'b1) begin
      fails++; $display("FAIL align_addr: addr=%h re=%b, required addr=00000204 re=1", mem_addr_o, mem_re_o);
    end
    wait_drain(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL b2b_drain: pending=%0d, required 0", exp_q.size()); end
  endtask

  task automatic test_write();
    bit ok;
    stall = 1;
    @(negedge clk_i);
    mem_d_rd_i = 1; mem_d_wr_i = 4'b0011; mem_d_addr_i = 32'h40;
    mem_d_data_wr_i = 32'hDEAD_BEEF; mem_d_req_tag_i = 11'h2A;
    wait_accept(ok);
    push_exp(1, 0, 32'h0, 11'h2A);
    @(negedge clk_i);
    set_idle();
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++;
      if (mem_we_o !== 1'b1 || mem_re_o !== 1'b0 || mem_wstrb_o !== 4'b0011 ||
          mem_addr_o !== 32'h40 || mem_wdata_o !== 32'hDEAD_BEEF) begin
        fails++;
        $display("FAIL write_hold_%0d: we=%b re=%b strb=%b addr=%h wdata=%h, required we=1 re=0 strb=0011 addr=00000040 wdata=deadbeef",
                 c, mem_we_o, mem_re_o, mem_wstrb_o, mem_addr_o, mem_wdata_o);
      end
      @(negedge clk_i);
    end
    stall = 0;
    wait_drain(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL write_drain: pending=%0d, required 0", exp_q.size()); end
  endtask

  task automatic test_range();
    bit ok;
    stall = 0;
    @(negedge clk_i);
    mem_d_rd_i = 1; mem_d_addr_i = 32'h0000_FFFF; mem_d_req_tag_i = 11'h11;
    wait_accept(ok);
    push_exp(1, 0, model_rdata(32'hFFFC), 11'h11);
    @(negedge clk_i);
    set_idle();
    #1;
    tests++;
    if (mem_re_o !== 1'b1 || mem_addr_o !== 32'hFFFC) begin
      fails++; $display("FAIL range_max_legal: re=%b addr=%h, required re=1 addr=0000fffc", mem_re_o, mem_addr_o);
    end
    wait_drain(ok);
    mem_d_rd_i = 1; mem_d_addr_i = 32'h0002_0000; mem_d_req_tag_i = 11'h7FF;
    wait_accept(ok);
    push_exp(1, 1, 32'h0, 11'h7FF);
    @(negedge clk_i);
    set_idle();
    #1;
    tests++;
    if (mem_re_o !== 1'b0 || mem_d_ack_o !== 1'b1 || mem_d_error_o !== 1'b1) begin
      fails++;
      $display("FAIL range_err_t1: re=%b ack=%b err=%b, required re=0 ack=1 err=1",
               mem_re_o, mem_d_ack_o, mem_d_error_o);
    end
    wait_drain(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL range_drain: pending=%0d, required 0", exp_q.size()); end
  endtask

  task automatic test_timeout();
    bit ok;
    int re_cycles;
    stall = 1;
    @(negedge clk_i);
    mem_d_rd_i = 1; mem_d_addr_i = 32'h300; mem_d_req_tag_i = 11'h3;
    wait_accept(ok);
    push_exp(1, 1, 32'h0, 11'h3);
    re_cycles = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i);
      set_idle();
      #1;
      if (mem_re_o) re_cycles++;
      if (mem_d_ack_o) break;
    end
    tests++;
    if (re_cycles != 8) begin
      fails++; $display("FAIL timeout_hold: re_cycles=%0d, required 8", re_cycles);
    end
    stall = 0;
    wait_drain(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL timeout_drain: pending=%0d, required 0", exp_q.size()); end
  endtask

  task automatic test_flush();
    bit ok;
    int seen_before;
    stall = 0;
    @(negedge clk_i);
    mem_i_rd_i = 1; mem_i_pc_i = 32'h100; mem_i_flush_i = 1;
    #1;
    tests++;
    if (mem_i_accept_o !== 1'b1) begin
      fails++; $display("FAIL flush_same_cycle_accept: accept=%b, required 1", mem_i_accept_o);
    end
    push_exp(0, 0, 32'h13, 11'h0);
    @(negedge clk_i);
    set_idle();
    wait_drain(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL flush_same_cycle_drain: pending=%0d, required 0", exp_q.size()); end
    stall = 1;
    seen_before = seen_i;
    mem_i_rd_i = 1; mem_i_pc_i = 32'h80;
    wait_accept(ok);
    @(negedge clk_i);
    set_idle();
    mem_i_flush_i = 1;
    @(negedge clk_i);
    mem_i_flush_i = 0;
    @(negedge clk_i);
    stall = 0;
    repeat (4) @(negedge clk_i);
    #3;
    tests++;
    if (seen_i != seen_before || mem_re_o !== 1'b0) begin
      fails++;
      $display("FAIL flush_suppress: fetch_resps=%0d re=%b, required fetch_resps=0 re=0",
               seen_i - seen_before, mem_re_o);
    end
  endtask

  task automatic test_reset_busy();
    bit ok;
    stall = 1;
    @(negedge clk_i);
    mem_d_rd_i = 1; mem_d_addr_i = 32'h400; mem_d_req_tag_i = 11'h1;
    wait_accept(ok);
    @(negedge clk_i);
    set_idle();
    @(negedge clk_i);
    rst_i = 1;
    mem_i_rd_i = 1; mem_i_pc_i = 32'h8;
    @(negedge clk_i);
    #1;
    tests++;
    if ({mem_re_o, mem_we_o, mem_d_ack_o, mem_i_valid_o, mem_i_accept_o, mem_d_accept_o, mem_addr_o} !== '0) begin
      fails++;
      $display("FAIL reset_busy_outputs: re=%b ack=%b accept=%b addr=%h, required all 0",
               mem_re_o, mem_d_ack_o, mem_i_accept_o, mem_addr_o);
    end
    rst_i = 0;
    stall = 0;
    #1;
    tests++;
    if (mem_i_accept_o !== 1'b1) begin
      fails++; $display("FAIL reset_busy_fetch_accept: accept=%b, required 1", mem_i_accept_o);
    end
    push_exp(0, 0, model_rdata(32'h8), 11'h0);
    @(negedge clk_i);
    set_idle();
    wait_drain(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL reset_busy_drain: pending=%0d, required 0", exp_q.size()); end
  endtask

  initial begin
    rst_i = 1;
    set_idle();
    test_reset();
    test_tie();
    test_back_to_back();
    test_write();
    test_range();
    test_timeout();
    test_flush();
    test_reset_busy();
    repeat (3) @(negedge clk_i);
    tests++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL final_queue: pending=%0d, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
